// File: rtl/ex1_vector_sweeper_if.sv
// Interface bundling the sweeper's control/status handshake and the driven/observed vector lines.
// The master side is the environment; the slave side is the sweeper.
interface ex1_vector_sweeper_if;
  logic        start;
  logic        w;
  logic        x;
  logic        y;
  logic        z;
  logic        in_b;
  logic        in_g;
  logic        in_d;
  logic        busy;
  logic        done;
  logic        pass;
  logic [4:0]  err_cnt;
  logic [3:0]  first_err_vec;
  logic [15:0] fail_mask;

  modport master (
    output start, in_b, in_g, in_d,
    input  w, x, y, z, busy, done, pass, err_cnt, first_err_vec, fail_mask
  );

  modport slave (
    input  start, in_b, in_g, in_d,
    output w, x, y, z, busy, done, pass, err_cnt, first_err_vec, fail_mask
  );
endinterface

// File: rtl/ex1_vector_sweeper.sv
// Sweeps all 16 {w,x,y,z} vectors, checks outB/outG/outD against f = y&w&(x|z).
// Optional per-vector failure mask enabled by defining EX1_FAIL_MASK_EN.
//
//  state  | meaning
//  IDLE   | waiting for start; results of last sweep held
//  SETTLE | current vector held while the logic under test settles
//  CMP    | compare cycle for the current vector
//  DONE   | sweep finished; done/pass published on the following cycle
module ex1_vector_sweeper #(
  parameter int SETTLE_CYC = 2
) (
  input logic               clk,
  input logic               rst,
  ex1_vector_sweeper_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, CMP, DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

  state_t      state;
  state_t      next_state;
  logic [3:0]  vec;
  logic [3:0]  settle_cnt;
  logic [4:0]  err_cnt;
  logic [3:0]  first_err_vec;
  logic        pass;
  logic        busy;
  logic        done;
  logic        busy_d;
  logic        done_d;
  logic        golden;
  logic        mismatch;

  assign golden   = vec[1] & vec[3] & (vec[2] | vec[0]);
  assign mismatch = (bus.in_b != golden) | (bus.in_g != golden) | (bus.in_d != golden);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start) next_state = SETTLE;
      SETTLE:  if (settle_cnt == SETTLE_LAST) next_state = CMP;
      CMP:     next_state = (vec == 4'hF) ? DONE : SETTLE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state)
      SETTLE, CMP: busy_d = 1'b1;
      DONE:        done_d = 1'b1;
      default:     ;
    endcase
  end

  // Status flags are registered from the state, so done and pass rise together.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec           <= 4'h0;
      settle_cnt    <= 4'h0;
      err_cnt       <= 5'd0;
      first_err_vec <= 4'h0;
      pass          <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      busy <= busy_d;
      done <= done_d;
      case (state)
        IDLE: begin
          if (bus.start) begin
            vec           <= 4'h0;
            settle_cnt    <= 4'h0;
            err_cnt       <= 5'd0;
            first_err_vec <= 4'h0;
            pass          <= 1'b0;
          end
        end
        SETTLE: settle_cnt <= settle_cnt + 4'd1;
        CMP: begin
          if (mismatch) begin
            err_cnt <= err_cnt + 5'd1;
            if (err_cnt == 5'd0) first_err_vec <= vec;
          end
          if (vec != 4'hF) begin
            vec        <= vec + 4'd1;
            settle_cnt <= 4'h0;
          end
        end
        DONE: begin
          pass <= (err_cnt == 5'd0);
          vec  <= 4'h0;
        end
        default: ;
      endcase
    end
  end

`ifdef EX1_FAIL_MASK_EN
  logic [15:0] fail_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      fail_mask <= 16'h0000;
    end else if (state == IDLE && bus.start) begin
      fail_mask <= 16'h0000;
    end else if (state == CMP && mismatch) begin
      fail_mask[vec] <= 1'b1;
    end
  end

  assign bus.fail_mask = fail_mask;
`else
  assign bus.fail_mask = 16'h0000;
`endif

  assign bus.w             = vec[3];
  assign bus.x             = vec[2];
  assign bus.y             = vec[1];
  assign bus.z             = vec[0];
  assign bus.busy          = busy;
  assign bus.done          = done;
  assign bus.pass          = pass;
  assign bus.err_cnt       = err_cnt;
  assign bus.first_err_vec = first_err_vec;

endmodule

// File: tb/tb_ex1_vector_sweeper.sv
// Scoreboard bench: the bench plays the combinational block (with injectable faults),
// a reference model predicts each sweep's result and a monitor checks it at done.
module tb_ex1_vector_sweeper;
  localparam int SC  = 2;
  localparam int LAT = 1 + 16 * (SC + 1);

  typedef struct {
    logic [4:0]  err;
    logic [3:0]  first;
    logic        pass;
    logic [15:0] mask;
    int          start_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  int          mode  = 0;
  logic [15:0] fmask = 16'h0;
  int          fout  = 0;

  exp_t q[$];

  ex1_vector_sweeper_if bus ();

  ex1_vector_sweeper #(.SETTLE_CYC(SC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behaviour of the block under test, optionally faulted.
  logic [3:0] vnow;
  logic       gold_f;
  logic       ob, og, od;
  assign vnow   = {bus.w, bus.x, bus.y, bus.z};
  assign gold_f = bus.y & bus.w & (bus.x | bus.z);

  always_comb begin
    ob = gold_f;
    og = gold_f;
    od = gold_f;
    case (mode)
      1: og = 1'b0;
      2: begin ob = ~gold_f; og = ~gold_f; od = ~gold_f; end
      3: if (fmask[vnow]) begin
           if (fout == 0) ob = ~gold_f;
           else if (fout == 1) og = ~gold_f;
           else od = ~gold_f;
         end
      default: ;
    endcase
  end

  assign bus.in_b = ob;
  assign bus.in_g = og;
  assign bus.in_d = od;

  logic start_r = 1'b0;
  assign bus.start = start_r;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Golden truth set is {B,E,F}; a vector fails if any output departs from it.
  function automatic exp_t model(input int m, input logic [15:0] fm, input int fo, input int sc);
    exp_t e;
    e.err = 0; e.first = 0; e.mask = 0; e.start_cyc = sc;
    for (int v = 0; v < 16; v++) begin
      bit g, b, gg, d;
      g = (v == 11 || v == 14 || v == 15);
      b = g; gg = g; d = g;
      if (m == 1) gg = 1'b0;
      if (m == 2) begin b = !g; gg = !g; d = !g; end
      if (m == 3 && fm[v]) begin
        if (fo == 0) b = !g; else if (fo == 1) gg = !g; else d = !g;
      end
      if (b != g || gg != g || d != g) begin
        if (e.err == 0) e.first = 4'(v);
        e.err  = e.err + 5'd1;
        e.mask[v] = 1'b1;
      end
    end
    e.pass = (e.err == 0);
`ifndef EX1_FAIL_MASK_EN
    e.mask = 16'h0000;
`endif
    return e;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("latency", 32'(cyc - e.start_cyc), 32'(LAT));
          chk("err_cnt", 32'(bus.err_cnt), 32'(e.err));
          chk("first_err_vec", 32'(bus.first_err_vec), 32'(e.first));
          chk("pass", 32'(bus.pass), 32'(e.pass));
          chk("fail_mask", 32'(bus.fail_mask), 32'(e.mask));
          chk("busy_at_done", 32'(bus.busy), 32'd0);
        end
      end
    end
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_vec"}, 32'(vnow), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_pass"}, 32'(bus.pass), 32'd0);
    chk({tag, "_err_cnt"}, 32'(bus.err_cnt), 32'd0);
    chk({tag, "_first"}, 32'(bus.first_err_vec), 32'd0);
    chk({tag, "_mask"}, 32'(bus.fail_mask), 32'd0);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("done_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic run_sweep(input int m, input logic [15:0] fm, input int fo, input bit extra);
    mode = m; fmask = fm; fout = fo;
    @(negedge clk);
    start_r = 1'b1;
    @(posedge clk);
    #1;
    start_r = 1'b0;
    q.push_back(model(m, fm, fo, cyc));
    if (extra) begin
      repeat (5) begin
        repeat ($urandom_range(1, 8)) @(negedge clk);
        start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
      end
    end
    wait_drain(LAT + 20);
  endtask

  initial begin : stim
    int c0;
    int n;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    @(negedge clk);
    rst = 1'b0;

    run_sweep(0, 16'h0, 0, 1'b0);
    chk("idle_pass_held", 32'(bus.pass), 32'd1);

    // Reset while idle clears held results.
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("idle_rst");
    @(negedge clk); rst = 1'b0;

    run_sweep(1, 16'h0, 0, 1'b0);
    run_sweep(2, 16'h0, 0, 1'b0);
    run_sweep(0, 16'h0, 0, 1'b1);
    run_sweep(1, 16'h0, 0, 1'b1);

    // Start held high: second sweep begins the cycle after IDLE is re-entered.
    mode = 2;
    @(negedge clk);
    start_r = 1'b1;
    @(posedge clk);
    #1;
    c0 = cyc;
    q.push_back(model(2, 16'h0, 0, c0));
    q.push_back(model(2, 16'h0, 0, c0 + LAT + 1));
    while (cyc < c0 + LAT + 10) @(negedge clk);
    start_r = 1'b0;
    wait_drain(2 * LAT + 20);

    // Reset during vector 7 aborts the sweep with no done.
    mode = 0;
    @(negedge clk);
    start_r = 1'b1;
    @(posedge clk);
    #1;
    start_r = 1'b0;
    n = 0;
    while (vnow != 4'h7 && n < 100) begin @(negedge clk); n++; end
    chk("reach_vec7", 32'(vnow), 32'd7);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_state("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (LAT + 5) begin
      @(negedge clk);
      chk("no_done_after_rst", 32'(bus.done), 32'd0);
    end
    run_sweep(0, 16'h0, 0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      run_sweep(3, 16'($urandom), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
